// File: rtl/reservoir_readout_pkg.sv
// rtl/reservoir_readout_pkg.sv - shared types, widths and saturation helper for the reservoir readout
//
// Package reservoir_pkg
//   idx_width()  : width of the node index / weight address
//   acc_width()  : accumulator width, 2*DATA_WIDTH + $clog2(VIRTUAL_NODES)
//   out_state_t  : output register state (EMPTY / FULL)
//   saturate()   : clamp a wide signed value to a DATA_WIDTH signed range
package reservoir_pkg;

  // Wide enough for any accumulator this block is built with.
  localparam int SAT_W = 128;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Clamp v to [-2^(dw-1), 2^(dw-1)-1]; the caller keeps the low dw bits.
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                        input int dw);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) << (dw - 1)) - SAT_W'(1);
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/reservoir_readout_if.sv
// rtl/reservoir_readout_if.sv - sample, weight-write and result signals of the reservoir readout
//
// Interface reservoir_readout_if
//   din / din_valid / frame_clr            : node sample stream (no backpressure)
//   weight_wr_en / weight_addr / weight_data : weight table write port
//   dout / dout_valid / dout_ready         : frame result handshake
//   overflow                               : sticky dropped-result flag
// Modports: slave = the readout block, master = whoever drives it.
interface reservoir_readout_if
  import reservoir_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int VIRTUAL_NODES = 10
) ();

  localparam int IW = idx_width(VIRTUAL_NODES);

  logic signed [DATA_WIDTH-1:0] din;
  logic                         din_valid;
  logic                         frame_clr;
  logic                         weight_wr_en;
  logic [IW-1:0]                weight_addr;
  logic signed [DATA_WIDTH-1:0] weight_data;
  logic signed [DATA_WIDTH-1:0] dout;
  logic                         dout_valid;
  logic                         dout_ready;
  logic                         overflow;

  modport slave (
    input  din, din_valid, frame_clr, weight_wr_en, weight_addr, weight_data, dout_ready,
    output dout, dout_valid, overflow
  );

  modport master (
    output din, din_valid, frame_clr, weight_wr_en, weight_addr, weight_data, dout_ready,
    input  dout, dout_valid, overflow
  );

endinterface

// File: rtl/reservoir_readout_mac.sv
// rtl/reservoir_readout_mac.sv - signed multiply-accumulate with shift/reduce of the frame sum
//
// Module readout_mac
//   clk, rst   : clock, synchronous active-high reset
//   din        : node sample
//   weight     : weight selected for this sample
//   sample_en  : din is valid this cycle
//   clr        : restart the frame; this cycle's sample (if any) is node 0
//   last       : this sample completes the frame
//   result     : combinational (acc + din*weight) >>> FRAC_BITS, reduced to DATA_WIDTH
// Build option: RESERVOIR_READOUT_SAT_EN selects saturation instead of wrap.
module readout_mac
  import reservoir_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int VIRTUAL_NODES = 10,
  parameter int FRAC_BITS     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic signed [DATA_WIDTH-1:0] weight,
  input  logic                         sample_en,
  input  logic                         clr,
  input  logic                         last,
  output logic signed [DATA_WIDTH-1:0] result
);

  localparam int ACC_W  = acc_width(DATA_WIDTH, VIRTUAL_NODES);
  localparam int PROD_W = 2 * DATA_WIDTH;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  base;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [PROD_W-1:0] prod;

  assign prod     = din * weight;
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

  // A frame restart makes the incoming sample node 0, so it must not see the old partial sum.
  always_comb begin
    base = acc;
    if (clr) base = '0;
  end

  assign sum     = base + prod_ext;
  assign shifted = sum >>> FRAC_BITS;

`ifdef RESERVOIR_READOUT_SAT_EN
  logic signed [SAT_W-1:0] sat_v;
  logic                    unused_sat;
  assign sat_v      = saturate(SAT_W'(shifted), DATA_WIDTH);
  assign result     = sat_v[DATA_WIDTH-1:0];
  assign unused_sat = ^sat_v[SAT_W-1:DATA_WIDTH];
`else
  logic unused_hi;
  assign result    = shifted[DATA_WIDTH-1:0];
  assign unused_hi = ^shifted[ACC_W-1:DATA_WIDTH];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (sample_en) begin
      acc <= last ? '0 : sum;
    end else if (clr) begin
      acc <= '0;
    end
  end

endmodule

// File: rtl/reservoir_readout.sv
// rtl/reservoir_readout.sv - per-frame weighted sum of reservoir node samples with valid/ready output
//
// Module reservoir_readout
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : reservoir_readout_if.slave (sample stream, weight writes, result handshake, overflow)
// Holds the node counter, the weight table and the one-entry output register.
// Build option: RESERVOIR_READOUT_SAT_EN (saturate instead of wrap, inside readout_mac).
module reservoir_readout
  import reservoir_pkg::*;
#(
  parameter int VIRTUAL_NODES = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int FRAC_BITS     = 16
) (
  input  logic                clk,
  input  logic                rst,
  reservoir_readout_if.slave  bus
);

  localparam int            IW       = idx_width(VIRTUAL_NODES);
  localparam logic [IW-1:0] LAST_IDX = IW'(VIRTUAL_NODES - 1);
  localparam logic [IW:0]   DEPTH    = (IW + 1)'(VIRTUAL_NODES);

  logic [IW-1:0]                idx;
  logic [IW-1:0]                cur_idx;
  logic                         last;
  logic signed [DATA_WIDTH-1:0] w [VIRTUAL_NODES];
  logic signed [DATA_WIDTH-1:0] mac_result;
  out_state_t                   state;

  // frame_clr turns a same-cycle sample into node 0 of a new frame.
  assign cur_idx = bus.frame_clr ? '0 : idx;
  assign last    = bus.din_valid && (cur_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (bus.din_valid) begin
      idx <= last ? '0 : cur_idx + 1'b1;
    end else if (bus.frame_clr) begin
      idx <= '0;
    end
  end

  // The MAC reads w[] before this edge's write lands, so a same-address write uses the old weight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < VIRTUAL_NODES; i++) w[i] <= '0;
    end else if (bus.weight_wr_en && ({1'b0, bus.weight_addr} < DEPTH)) begin
      w[bus.weight_addr] <= bus.weight_data;
    end
  end

  readout_mac #(
    .DATA_WIDTH    (DATA_WIDTH),
    .VIRTUAL_NODES (VIRTUAL_NODES),
    .FRAC_BITS     (FRAC_BITS)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .din       (bus.din),
    .weight    (w[cur_idx]),
    .sample_en (bus.din_valid),
    .clr       (bus.frame_clr),
    .last      (last),
    .result    (mac_result)
  );

  // One-entry output register. A completion while FULL replaces the held result only if it is
  // being consumed in the same cycle; otherwise the new result is lost and overflow latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= OUT_EMPTY;
      bus.dout     <= '0;
      bus.overflow <= 1'b0;
    end else begin
      case (state)
        OUT_EMPTY: begin
          if (last) begin
            bus.dout <= mac_result;
            state    <= OUT_FULL;
          end
        end
        OUT_FULL: begin
          if (last) begin
            if (bus.dout_ready) bus.dout <= mac_result;
            else                bus.overflow <= 1'b1;
          end else if (bus.dout_ready) begin
            state <= OUT_EMPTY;
          end
        end
        default: state <= OUT_EMPTY;
      endcase
    end
  end

  assign bus.dout_valid = (state == OUT_FULL);

endmodule

// File: tb/tb_reservoir_readout.sv
// tb/tb_reservoir_readout.sv - scoreboard bench for reservoir_readout
module tb_reservoir_readout;

  localparam int VN  = 10;
  localparam int DW  = 32;
  localparam logic [31:0] ONE = 32'h0001_0000;
`ifdef RESERVOIR_READOUT_SAT_EN
  localparam logic [31:0] SAT_EXP = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] SAT_EXP = 32'hFFF6_0000;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reservoir_readout_if #(.DATA_WIDTH(DW), .VIRTUAL_NODES(VN)) bus ();

  reservoir_readout #(
    .VIRTUAL_NODES (VN),
    .DATA_WIDTH    (DW),
    .FRAC_BITS     (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every result the consumer takes is compared against the next expected value.
  always @(negedge clk) begin
    if (!rst && bus.dout_valid === 1'b1 && bus.dout_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h expected none", bus.dout);
      end else begin
        check("result", bus.dout, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input logic [3:0] addr, input logic [31:0] data);
    bus.weight_wr_en = 1'b1;
    bus.weight_addr  = addr;
    bus.weight_data  = data;
    tick();
    bus.weight_wr_en = 1'b0;
  endtask

  task automatic set_all(input logic [31:0] data);
    for (int i = 0; i < VN; i++) write_w(4'(i), data);
  endtask

  task automatic send_frame(input logic [31:0] s, input int max_gap);
    for (int i = 0; i < VN; i++) begin
      bus.din       = s;
      bus.din_valid = 1'b1;
      tick();
      bus.din_valid = 1'b0;
      if (max_gap > 0 && i < VN - 1) repeat ($urandom_range(max_gap, 0)) tick();
    end
    check("latency_valid", {31'b0, bus.dout_valid}, 32'd1);
  endtask

  initial begin
    rst              = 1'b1;
    bus.din          = '0;
    bus.din_valid    = 1'b0;
    bus.frame_clr    = 1'b0;
    bus.weight_wr_en = 1'b0;
    bus.weight_addr  = '0;
    bus.weight_data  = '0;
    bus.dout_ready   = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check("reset_dout", bus.dout, 32'h0);
    check("reset_valid", {31'b0, bus.dout_valid}, 32'h0);
    check("reset_overflow", {31'b0, bus.overflow}, 32'h0);

    // Zero weights after reset.
    exp_q.push_back(32'h0);
    send_frame(ONE, 0);

    // Unit weights: +1.0 and -1.0 samples.
    set_all(ONE);
    exp_q.push_back(32'h000A_0000);
    send_frame(ONE, 0);
    exp_q.push_back(32'hFFF6_0000);
    send_frame(32'hFFFF_0000, 0);

    // Held result, dropped second frame, then replace-on-consume.
    tick();
    bus.dout_ready = 1'b0;
    exp_q.push_back(32'h0014_0000);
    send_frame(32'h0002_0000, 0);
    send_frame(32'h0003_0000, 0);
    check("overflow_set", {31'b0, bus.overflow}, 32'd1);
    check("held_dout", bus.dout, 32'h0014_0000);
    exp_q.push_back(32'h0028_0000);
    for (int i = 0; i < VN; i++) begin
      if (i == VN - 1) bus.dout_ready = 1'b1;
      bus.din       = 32'h0004_0000;
      bus.din_valid = 1'b1;
      tick();
    end
    bus.din_valid = 1'b0;
    check("replace_valid", {31'b0, bus.dout_valid}, 32'd1);
    check("replace_dout", bus.dout, 32'h0028_0000);
    repeat (3) tick();
    check("overflow_sticky", {31'b0, bus.overflow}, 32'd1);

    // frame_clr after 4 samples, together with a valid sample.
    exp_q.push_back(32'h000A_0000);
    for (int i = 0; i < 4; i++) begin
      bus.din       = 32'h0005_0000;
      bus.din_valid = 1'b1;
      tick();
    end
    bus.frame_clr = 1'b1;
    for (int i = 0; i < VN; i++) begin
      bus.din       = ONE;
      bus.din_valid = 1'b1;
      tick();
      bus.frame_clr = 1'b0;
    end
    bus.din_valid = 1'b0;
    check("clr_latency_valid", {31'b0, bus.dout_valid}, 32'd1);

    // Full-scale samples and weights.
    set_all(32'h7FFF_FFFF);
    exp_q.push_back(SAT_EXP);
    send_frame(32'h7FFF_FFFF, 0);

    // Weight write on the node being consumed, and an out-of-range address.
    set_all(ONE);
    exp_q.push_back(32'h000A_0000);
    for (int i = 0; i < VN; i++) begin
      bus.din       = ONE;
      bus.din_valid = 1'b1;
      if (i == 3) begin
        bus.weight_wr_en = 1'b1;
        bus.weight_addr  = 4'd3;
        bus.weight_data  = 32'h0002_0000;
      end
      if (i == 5) begin
        bus.weight_wr_en = 1'b1;
        bus.weight_addr  = 4'd12;
        bus.weight_data  = 32'h7FFF_FFFF;
      end
      tick();
      bus.weight_wr_en = 1'b0;
    end
    bus.din_valid = 1'b0;
    exp_q.push_back(32'h000B_0000);
    send_frame(ONE, 3);
    exp_q.push_back(32'h0005_8000);
    send_frame(32'h0000_8000, 2);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
